// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and frame constants.
// Used by both uart_tx and uart_rx so the two ends always agree on framing.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // States carry a TX_ prefix so they cannot collide with the PARITY parameter name.
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // Even mode sends the XOR of the data bits; odd mode sends its inverse.
  function automatic logic parity_bit(input logic xor_acc, input int mode);
    return (mode == PARITY_ODD) ? ~xor_acc : xor_acc;
  endfunction

endpackage

// File: rtl/axis_interface.sv
// Minimal AXI-Stream bundle shared by the UART transmit and receive paths.
// Both ends of the stream run on the UART's own clk.
interface axis_interface #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport slave  (input  tdata, input  tvalid, output tready);
  modport master (output tdata, output tvalid, input  tready);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and strobes o_tick on the last cycle.
// i_restart holds the count at zero so the next period starts cleanly.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST_CNT) && !i_restart;

  // NOTE: state lives in always_ff with non-blocking assignments only, so every
  // flop samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_restart || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// A one-byte holding register in front of the shifter allows gap-free back-to-back frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic         clk,
  input  logic         reset,
  axis_interface.slave tx_stream,
  output logic         txd,
  output logic         busy
);

  localparam logic [2:0] LAST_DATA_IDX = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP_IDX = 3'(STOP_BITS - 1);

  tx_state_t r_state;
  tx_state_t w_state_next;

  logic [UART_DATA_BITS-1:0] r_hold_data;
  logic                      r_hold_valid;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_next;
  logic [2:0]                r_bit_cnt;
  logic [2:0]                w_bit_cnt_next;
  logic                      r_par_acc;
  logic                      w_par_acc_next;
  logic                      r_txd;
  logic                      w_txd_next;

  logic w_tick;
  logic w_accept;
  logic w_load;
  logic w_last_data;
  logic w_last_stop;

  assign tx_stream.tready = reset && !r_hold_valid;
  assign w_accept         = tx_stream.tvalid && tx_stream.tready;

  assign w_last_data = (r_bit_cnt == LAST_DATA_IDX);
  assign w_last_stop = (r_bit_cnt == LAST_STOP_IDX);

  // The held byte moves to the shifter from IDLE, or straight out of the final stop period.
  assign w_load = r_hold_valid &&
                  ((r_state == TX_IDLE) || ((r_state == TX_STOP) && w_tick && w_last_stop));

  assign busy = (r_state != TX_IDLE) || r_hold_valid;
  assign txd  = r_txd;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk      (clk),
    .reset    (reset),
    .i_restart(r_state == TX_IDLE),
    .o_tick   (w_tick)
  );

  // NOTE: the holding data register is reset too; it is only 8 flops, and a
  // defined value keeps the post-reset behaviour identical in every simulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (w_load) begin
      r_hold_valid <= 1'b0;
    end else if (w_accept) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= tx_stream.tdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= TX_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      TX_IDLE: begin
        if (r_hold_valid) w_state_next = TX_START;
      end
      TX_START: begin
        if (w_tick) w_state_next = TX_DATA;
      end
      TX_DATA: begin
        if (w_tick && w_last_data) begin
          w_state_next = (PARITY != PARITY_NONE) ? TX_PARITY : TX_STOP;
        end
      end
      TX_PARITY: begin
        if (w_tick) w_state_next = TX_STOP;
      end
      TX_STOP: begin
        if (w_tick && w_last_stop) begin
          w_state_next = r_hold_valid ? TX_START : TX_IDLE;
        end
      end
      default: w_state_next = TX_IDLE;
    endcase
  end

  // The bit counter wraps 7 -> 0 at the end of data, ready to count stop periods.
  always_comb begin
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_par_acc_next = r_par_acc;
    if (w_load) begin
      w_shift_next   = r_hold_data;
      w_bit_cnt_next = '0;
      w_par_acc_next = 1'b0;
    end else if (w_tick) begin
      case (r_state)
        TX_DATA: begin
          w_shift_next   = {1'b0, r_shift[UART_DATA_BITS-1:1]};
          w_par_acc_next = r_par_acc ^ r_shift[0];
          w_bit_cnt_next = r_bit_cnt + 3'd1;
        end
        TX_STOP: begin
          w_bit_cnt_next = w_last_stop ? 3'd0 : r_bit_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Output decode looks at next-state values so the registered txd lines up with the state.
  always_comb begin
    w_txd_next = 1'b1;
    case (w_state_next)
      TX_START:  w_txd_next = 1'b0;
      TX_DATA:   w_txd_next = w_shift_next[0];
      TX_PARITY: w_txd_next = parity_bit(w_par_acc_next, PARITY);
      default:   w_txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par_acc <= 1'b0;
      r_txd     <= 1'b1;
    end else begin
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_par_acc <= w_par_acc_next;
      r_txd     <= w_txd_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three instances (no parity/1 stop, even/2 stop, odd/1 stop
// at 3 clocks per bit) compared cycle by cycle against a frame model built from the framing rules.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] r_tdata  [3];
  logic       r_tvalid [3];
  wire  [2:0] w_txd;
  wire  [2:0] w_busy;
  wire  [2:0] w_tready;

  axis_interface #(.DATA_W(8)) u_if0 ();
  axis_interface #(.DATA_W(8)) u_if1 ();
  axis_interface #(.DATA_W(8)) u_if2 ();

  assign u_if0.tdata  = r_tdata[0];
  assign u_if0.tvalid = r_tvalid[0];
  assign u_if1.tdata  = r_tdata[1];
  assign u_if1.tvalid = r_tvalid[1];
  assign u_if2.tdata  = r_tdata[2];
  assign u_if2.tvalid = r_tvalid[2];
  assign w_tready[0]  = u_if0.tready;
  assign w_tready[1]  = u_if1.tready;
  assign w_tready[2]  = u_if2.tready;

  uart_tx #(.CLKS_PER_BIT(2), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .reset(rst_n), .tx_stream(u_if0), .txd(w_txd[0]), .busy(w_busy[0]));
  uart_tx #(.CLKS_PER_BIT(2), .PARITY(2), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .reset(rst_n), .tx_stream(u_if1), .txd(w_txd[1]), .busy(w_busy[1]));
  uart_tx #(.CLKS_PER_BIT(3), .PARITY(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .reset(rst_n), .tx_stream(u_if2), .txd(w_txd[2]), .busy(w_busy[2]));

  function automatic int cpb_of(input int k);
    return (k == 2) ? 3 : 2;
  endfunction

  function automatic int par_of(input int k);
    return (k == 1) ? 2 : (k == 2) ? 1 : 0;
  endfunction

  function automatic int stop_of(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  function automatic int frame_cycles(input int k);
    return cpb_of(k) * (10 + ((par_of(k) != 0) ? 1 : 0) + (stop_of(k) - 1));
  endfunction

  // Line level during bit period idx of a frame carrying d.
  function automatic logic model_bit(input int k, input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (par_of(k) != 0 && idx == 9) return (par_of(k) == 2) ? ^d : ~^d;
    return 1'b1;
  endfunction

  // Offer one byte at a negedge and hold it until tready; acc is the accepting posedge.
  task automatic push_byte(input int k, input logic [7:0] b, output int acc);
    int w;
    w = 0;
    r_tdata[k]  = b;
    r_tvalid[k] = 1'b1;
    while (w_tready[k] !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    n_assert++;
    if (w_tready[k] !== 1'b1) begin
      n_fail++;
      $display("FAIL tready_timeout dut%0d byte %02h: tready=%b after %0d cycles, required 1",
               k, b, w_tready[k], w);
      acc = -1;
    end else begin
      acc = cyc + 1;
    end
    @(negedge clk);
  endtask

  // Push q with tvalid held high while sampling txd/busy every cycle of the frames.
  task automatic send_frames(input int k, input logic [7:0] q[$], input string name,
                             output logic par_smp);
    int         n, f, c, t0, w, bad;
    int         acc[$];
    logic       smp[$];
    logic       bsy[$];
    logic       post_txd, post_busy, got, expv, busy_ok;
    logic [7:0] dec;
    n = q.size();
    f = frame_cycles(k);
    c = cpb_of(k);
    t0 = -1;
    post_txd = 1'bx;
    post_busy = 1'bx;
    par_smp = 1'bx;
    fork
      begin
        for (int j = 0; j < n; j++) begin
          int a;
          push_byte(k, q[j], a);
          acc.push_back(a);
        end
        r_tvalid[k] = 1'b0;
      end
      begin
        w = 0;
        while (w_txd[k] !== 1'b0 && w < 200) begin
          @(negedge clk);
          w++;
        end
        if (w_txd[k] === 1'b0) begin
          t0 = cyc;
          for (int i = 0; i < n * f; i++) begin
            smp.push_back(w_txd[k]);
            bsy.push_back(w_busy[k]);
            @(negedge clk);
          end
          post_txd  = w_txd[k];
          post_busy = w_busy[k];
        end
      end
    join

    n_assert++;
    if (t0 < 0) begin
      n_fail++;
      $display("FAIL %s start_timeout dut%0d: txd=%b, required a start bit within 200 cycles",
               name, k, w_txd[k]);
      return;
    end
    n_assert++;
    if (t0 !== acc[0] + 1) begin
      n_fail++;
      $display("FAIL %s latency dut%0d: start bit at cycle %0d, required %0d", name, k, t0, acc[0] + 1);
    end
    par_smp = smp[9 * c];
    for (int j = 0; j < n; j++) begin
      bad = -1;
      got = 1'b0;
      expv = 1'b0;
      busy_ok = 1'b1;
      for (int i = 0; i < f; i++) begin
        if (smp[j*f+i] !== model_bit(k, q[j], i / c) && bad < 0) begin
          bad  = i;
          got  = smp[j*f+i];
          expv = model_bit(k, q[j], i / c);
        end
        if (bsy[j*f+i] !== 1'b1) busy_ok = 1'b0;
      end
      n_assert++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL %s line dut%0d frame %0d byte %02h: cycle %0d txd=%b, required %b",
                 name, k, j, q[j], bad, got, expv);
      end
      n_assert++;
      if (busy_ok !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy dut%0d frame %0d: busy dropped inside frame, required 1", name, k, j);
      end
      for (int b = 0; b < 8; b++) dec[b] = smp[j*f + (1 + b) * c + c / 2];
      n_assert++;
      if (dec !== q[j]) begin
        n_fail++;
        $display("FAIL %s rx_decode dut%0d frame %0d: got %02h, required %02h", name, k, j, dec, q[j]);
      end
      if (j >= 1) begin
        n_assert++;
        if (acc[j] !== t0 + (j - 1) * f + 1) begin
          n_fail++;
          $display("FAIL %s accept_cycle dut%0d byte %0d: accepted at %0d, required %0d",
                   name, k, j, acc[j], t0 + (j - 1) * f + 1);
        end
      end
    end
    n_assert++;
    if (post_txd !== 1'b1 || post_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s frame_end dut%0d: txd=%b busy=%b, required txd=1 busy=0",
               name, k, post_txd, post_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      r_tvalid[k] = 1'b0;
      r_tdata[k]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_assert++;
      if (w_txd[k] !== 1'b1 || w_busy[k] !== 1'b0 || w_tready[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold dut%0d: txd=%b busy=%b tready=%b, required 1 0 0",
                 k, w_txd[k], w_busy[k], w_tready[k]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_assert++;
      if (w_txd[k] !== 1'b1 || w_busy[k] !== 1'b0 || w_tready[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_release dut%0d: txd=%b busy=%b tready=%b, required 1 0 1",
                 k, w_txd[k], w_busy[k], w_tready[k]);
      end
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] q[$];
    logic       p;
    q.push_back(8'h0A);
    send_frames(0, q, "single", p);
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic       p;
    q.push_back(8'h0A);
    q.push_back(8'h0B);
    q.push_back(8'h0C);
    send_frames(0, q, "b2b", p);
  endtask

  task automatic test_parity_stop();
    logic [7:0] q[$];
    logic       p;
    q.push_back(8'h0B);
    send_frames(1, q, "parity_even", p);
    n_assert++;
    if (p !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_even_bit: got %b, required 1", p);
    end
    send_frames(2, q, "parity_odd", p);
    n_assert++;
    if (p !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_odd_bit: got %b, required 0", p);
    end
  endtask

  task automatic test_reset_mid_frame();
    int         a0, a1, t0;
    logic [7:0] q[$];
    logic       p, idle_ok;
    push_byte(0, 8'h55, a0);
    push_byte(0, 8'h33, a1);
    r_tvalid[0] = 1'b0;
    t0 = a0 + 1;
    while (cyc < t0 + 8) @(negedge clk);
    n_assert++;
    if (w_txd[0] !== model_bit(0, 8'h55, 4)) begin
      n_fail++;
      $display("FAIL midframe_bit3: txd=%b, required %b", w_txd[0], model_bit(0, 8'h55, 4));
    end
    #1 rst_n = 1'b0;
    #1;
    n_assert++;
    if (w_txd[0] !== 1'b1 || w_busy[0] !== 1'b0 || w_tready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_async_reset: txd=%b busy=%b tready=%b, required 1 0 0",
               w_txd[0], w_busy[0], w_tready[0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_ok = 1'b1;
    for (int i = 0; i < 2 * frame_cycles(0); i++) begin
      @(negedge clk);
      if (w_txd[0] !== 1'b1 || w_busy[0] !== 1'b0) idle_ok = 1'b0;
    end
    n_assert++;
    if (idle_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_hold_discard: line left idle=%b, required 1", idle_ok);
    end
    q.push_back(8'hA5);
    send_frames(0, q, "after_reset", p);
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic       p;
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 3; r++) begin
        q.delete();
        q.push_back(8'($urandom_range(0, 255)));
        send_frames(k, q, "rand_single", p);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      q.delete();
      for (int r = 0; r < 3; r++) q.push_back(8'($urandom_range(0, 255)));
      send_frames(k, q, "rand_burst", p);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_parity_stop();
    test_reset_mid_frame();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serializes bytes from an AXI-Stream slave onto a single `txd` line. Frame order is start bit, data LSB first, optional parity, then 1 or 2 stop bits. It is the transmit counterpart of `uart_rx`, uses the same `CLKS_PER_BIT` timing model and the same `axis_interface` stream, and sits between a system-side byte producer and the pin. A one-entry holding register lets frames go out back-to-back with no idle gap.

## Interface
- `CLKS_PER_BIT`, 2: `clk` cycles per bit period; must be ≥ 2.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `clk`  input  1: single clock. `tx_stream.clk` must be driven by this same clock.
- `reset`  input  1: asynchronous, active-low reset.
- `tx_stream`  axis_interface (slave)  8-bit `tdata`: input bytes, with `tvalid`/`tready` handshake.
- `txd`  output  1: serial line, idle high.
- `busy`  output  1: high while a frame is on the line or a byte is held.

## Operation
- **Holding register.**
  - `hold_data[7:0]` and `hold_valid`.
  - `tready = reset && !hold_valid`.
  - A beat is accepted when `tvalid && tready`; it sets `hold_valid` and captures `tdata`.
- **State machine** `tx_state_t`: `IDLE`, `START`, `DATA`, `PARITY`, `STOP`.
  - `IDLE`: `txd=1`. If `hold_valid`, load `shift_reg <= hold_data`, clear `hold_valid`, go to `START`.
  - `START`: `txd=0` for one bit period, then go to `DATA`.
  - `DATA`: `txd=shift_reg[0]`. Shift right at each bit-period end. After 8 bits, go to `PARITY` if `PARITY!=0`, else go to `STOP`.
  - `PARITY`: `txd` = XOR of the 8 data bits for even mode, or its inverse for odd mode. Lasts one bit period, then go to `STOP`.
  - `STOP`: `txd=1` for `STOP_BITS` bit periods.
    - At the end of the last stop period with `hold_valid` set: load the shifter and go directly to `START`, giving back-to-back frames.
    - Otherwise go to `IDLE`.
- **Counters.**
  - Baud counter is `$clog2(CLKS_PER_BIT)` bits wide. It counts 0..`CLKS_PER_BIT-1`, and the bit period ends at `CLKS_PER_BIT-1`. It resets to 0 on each state entry.
  - Bit counter is 3 bits for data, and is reused for the stop-bit count.
  - Parity accumulator is 1 bit, XOR-updated as each data bit is emitted.
- **Simultaneous events.** If the holding register is loaded into the shifter in the same cycle a new beat arrives, the new beat is not accepted: `tready` was low, and rises the next cycle.
- **`busy`** `= (state != IDLE) || hold_valid`.

## Timing
- **Reset values:**
  - `txd=1`, `busy=0`, `tready=0` while reset is asserted.
  - `state=IDLE`, `hold_valid=0`, all counters 0.
  - Reset mid-frame aborts the frame: `txd` returns high immediately (asynchronously) and the held byte is discarded.
- **Output register.** `txd` is registered, with no combinational path from `tdata`.
- **Latency.** With the shifter idle:
  - Beat accepted at edge N.
  - `IDLE` sees `hold_valid` and `txd` falls at edge N+1.
  - Hence the start bit begins 1 cycle after acceptance.
- **Frame length** = `CLKS_PER_BIT × (10 + (PARITY!=0) + (STOP_BITS-1))` cycles.
- **Back-to-back.** The next start bit follows the last stop-bit cycle with zero idle cycles.
- **`tready`** re-asserts the cycle after the held byte moves to the shifter. That is at most one frame, so the producer sees at most one frame of stall.

## Structure
- Package `uart_pkg` holds:
  - `tx_state_t`;
  - parity mode constants `PARITY_NONE`, `PARITY_ODD`, `PARITY_EVEN`;
  - `UART_DATA_BITS = 8`.
- `uart_rx` uses the same package.
- Natural sub-module: `uart_baud_tick`, a parameterized counter producing a one-cycle end-of-bit strobe with a synchronous restart input. It is shareable with `uart_rx`.

## Test plan
- **Single byte.** `CLKS_PER_BIT=2`, send 0x0A.
  - `txd` per bit period: 0 | 0,1,0,1,0,0,0,0 | 1, each held 2 cycles.
  - Start bit begins 1 cycle after acceptance; `busy` is high for exactly 20 cycles after that.
- **Back-to-back.** Send 0x0A, 0x0B, 0x0C with `tvalid` held high.
  - 30 contiguous bit periods with no idle between stop and start.
  - Loopback into `uart_rx` yields 10, 11, 12.
- **Backpressure.** During the first frame, 0x0B is accepted immediately and 0x0C stalls.
  - `tready` stays low until the cycle after 0x0B loads into the shifter.
- **Parity and stop bits.** `PARITY=2`, `STOP_BITS=2`, send 0x0B.
  - Parity bit = 1, followed by 2 stop periods; total frame 24 cycles.
  - With `PARITY=1` the same byte gives parity bit 0.
- **Reset mid-frame.** Assert `reset` low during the 4th data bit of 0x55.
  - `txd` goes to 1 the same cycle, `busy=0`, `tready=0`.
  - After release, 0xA5 transmits as a clean frame.
